// File: rtl/tri_scan.sv
// tri_scan: walks a width x height box in raster order, stepping EDGES edge
// functions per pixel. Define TRI_SCAN_ROW_SKIP_EN to end a row early once it leaves the triangle.
module tri_scan #(
    parameter int W     = 18,
    parameter int EDGES = 3,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [W*EDGES-1:0]   a,
    input  logic [W*EDGES-1:0]   b,
    input  logic [W*EDGES-1:0]   c,
    input  logic [XW-1:0]        width,
    input  logic [YW-1:0]        height,
    input  logic                 start,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XW-1:0]        out_x,
    output logic [YW-1:0]        out_y,
    output logic                 out_inside,
    output logic                 out_last,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic [W*EDGES-1:0]   a_q, a_d;
    logic [W*EDGES-1:0]   b_q, b_d;
    logic [W*EDGES-1:0]   e_q, e_d;
    logic [W*EDGES-1:0]   er_q, er_d;
    logic [XW-1:0]        width_q, width_d;
    logic [YW-1:0]        height_q, height_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;

    logic [W*EDGES-1:0]   e_step;
    logic [W*EDGES-1:0]   er_step;
    logic [EDGES-1:0]     edge_neg;

    logic                 load;
    logic                 accept;
    logic                 pix_inside;
    logic                 row_skip;
    logic                 col_end;
    logic                 row_last;

    // Each edge is an independent W-bit adder; overflow simply wraps.
    for (genvar k = 0; k < EDGES; k++) begin : g_edge
        assign e_step[W*k +: W]  = e_q[W*k +: W]  + a_q[W*k +: W];
        assign er_step[W*k +: W] = er_q[W*k +: W] + b_q[W*k +: W];
        assign edge_neg[k]       = e_q[W*k + W - 1];
    end

    assign load       = (state_q == IDLE) && start;
    assign accept     = (state_q == RUN) && out_ready;
    assign pix_inside = ~|edge_neg;
    assign col_end    = (x_q == width_q - XW'(1)) || row_skip;
    assign row_last   = (y_q == height_q - YW'(1));

`ifdef TRI_SCAN_ROW_SKIP_EN
    logic seen_in_q, seen_in_d;

    // A convex triangle cannot re-enter a row once it has been left.
    assign row_skip = seen_in_q && !pix_inside;

    always_comb begin
        seen_in_d = seen_in_q;
        if (load) begin
            seen_in_d = 1'b0;
        end else if (accept) begin
            seen_in_d = col_end ? 1'b0 : (seen_in_q | pix_inside);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seen_in_q <= 1'b0;
        end else begin
            seen_in_q <= seen_in_d;
        end
    end
`else
    assign row_skip = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ((width == '0) || (height == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && col_end && row_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        out_valid  = (state_q == RUN);
        done       = (state_q == DONE);
        out_x      = x_q;
        out_y      = y_q;
        out_inside = out_valid && pix_inside;
        out_last   = out_valid && col_end && row_last;
    end

    // Scan datapath: load on start, step on each accepted pixel.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        width_d  = width_q;
        height_d = height_q;
        e_d      = e_q;
        er_d     = er_q;
        x_d      = x_q;
        y_d      = y_q;
        if (load) begin
            a_d      = a;
            b_d      = b;
            width_d  = width;
            height_d = height;
            e_d      = c;
            er_d     = c;
            x_d      = '0;
            y_d      = '0;
        end else if (accept) begin
            if (!col_end) begin
                x_d = x_q + XW'(1);
                e_d = e_step;
            end else if (!row_last) begin
                x_d  = '0;
                y_d  = y_q + YW'(1);
                er_d = er_step;
                e_d  = er_step;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_q  <= '0;
            er_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            e_q  <= e_d;
            er_q <= er_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    // NOTE: latched scan parameters need no reset; they are always loaded before first use.
    always_ff @(posedge clock) begin
        a_q      <= a_d;
        b_q      <= b_d;
        width_q  <= width_d;
        height_q <= height_d;
    end

endmodule

// File: tb/tb_tri_scan.sv
// tb_tri_scan: directed-vector bench for tri_scan; each scenario captures a
// per-cycle output trace and compares it against hand-computed expectations.
module tb_tri_scan;

    localparam int W     = 18;
    localparam int EDGES = 3;
    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int BW    = W * EDGES;
    localparam int TMAX  = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [BW-1:0] a, b, c;
    logic [XW-1:0] width;
    logic [YW-1:0] height;
    logic          start;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_inside;
    logic          out_last;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic          tr_valid  [TMAX];
    logic          tr_inside [TMAX];
    logic          tr_last   [TMAX];
    logic          tr_done   [TMAX];
    logic          tr_busy   [TMAX];
    logic          tr_acc    [TMAX];
    logic [XW-1:0] tr_x      [TMAX];
    logic [YW-1:0] tr_y      [TMAX];

    always #5 clock = ~clock;

    tri_scan #(.W(W), .EDGES(EDGES), .XW(XW), .YW(YW)) dut (
        .clock      (clock),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .width      (width),
        .height     (height),
        .start      (start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_inside (out_inside),
        .out_last   (out_last),
        .done       (done)
    );

    function automatic logic [BW-1:0] pack3(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                            input logic [W-1:0] e2);
        return {e2, e1, e0};
    endfunction

    // Drives one start pulse; returns on the falling edge where pixel (0,0) is visible.
    task automatic do_start(input logic [BW-1:0] a_v, input logic [BW-1:0] b_v,
                            input logic [BW-1:0] c_v, input logic [XW-1:0] w_v,
                            input logic [YW-1:0] h_v);
        @(negedge clock);
        a = a_v; b = b_v; c = c_v; width = w_v; height = h_v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Records ncyc cycles of outputs; optional stall window, start poke and reset pulse.
    task automatic run_trace(input int ncyc, input int stall_at, input int stall_len,
                             input int poke_at, input logic [BW-1:0] poke_c, input int reset_at);
        for (int k = 0; k < ncyc; k++) begin
            out_ready = !((k >= stall_at) && (k < stall_at + stall_len));
            start     = (k == poke_at);
            reset     = (k == reset_at);
            if (k == poke_at) c = poke_c;
            tr_valid[k]  = out_valid;
            tr_inside[k] = out_inside;
            tr_last[k]   = out_last;
            tr_done[k]   = done;
            tr_busy[k]   = busy;
            tr_x[k]      = out_x;
            tr_y[k]      = out_y;
            tr_acc[k]    = out_valid && out_ready;
            @(negedge clock);
        end
        start = 1'b0;
        reset = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; width = '0; height = '0;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b expected 0", out_valid); end
        n_checks++; if (out_x !== '0) begin n_fail++; $display("FAIL reset out_x got %0d expected 0", out_x); end
        n_checks++; if (out_y !== '0) begin n_fail++; $display("FAIL reset out_y got %0d expected 0", out_y); end
        n_checks++; if (out_inside !== 1'b0) begin n_fail++; $display("FAIL reset out_inside got %b expected 0", out_inside); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last got %b expected 0", out_last); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b expected 0", done); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset idle busy got %b expected 0", busy); end
    endtask

    task automatic test_full_box();
        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(12, -1, 0, -1, '0, -1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (tr_valid[k] !== 1'b1) begin n_fail++; $display("FAIL full_box valid k=%0d got %b expected 1", k, tr_valid[k]); end
            n_checks++; if (tr_x[k] !== XW'(k % 4)) begin n_fail++; $display("FAIL full_box x k=%0d got %0d expected %0d", k, tr_x[k], k % 4); end
            n_checks++; if (tr_y[k] !== YW'(k / 4)) begin n_fail++; $display("FAIL full_box y k=%0d got %0d expected %0d", k, tr_y[k], k / 4); end
            n_checks++; if (tr_inside[k] !== 1'b1) begin n_fail++; $display("FAIL full_box inside k=%0d got %b expected 1", k, tr_inside[k]); end
            n_checks++; if (tr_last[k] !== (k == 7)) begin n_fail++; $display("FAIL full_box last k=%0d got %b expected %b", k, tr_last[k], k == 7); end
            n_checks++; if (tr_done[k] !== 1'b0) begin n_fail++; $display("FAIL full_box early done k=%0d got %b expected 0", k, tr_done[k]); end
        end
        n_checks++; if (tr_valid[8] !== 1'b0) begin n_fail++; $display("FAIL full_box valid after last got %b expected 0", tr_valid[8]); end
        n_checks++; if (tr_done[8] !== 1'b1) begin n_fail++; $display("FAIL full_box done got %b expected 1", tr_done[8]); end
        n_checks++; if (tr_busy[8] !== 1'b1) begin n_fail++; $display("FAIL full_box busy in done got %b expected 1", tr_busy[8]); end
        n_checks++; if (tr_busy[9] !== 1'b0) begin n_fail++; $display("FAIL full_box busy after done got %b expected 0", tr_busy[9]); end
        n_checks++; if (tr_done[9] !== 1'b0) begin n_fail++; $display("FAIL full_box done width got %b expected 0", tr_done[9]); end
    endtask

    task automatic test_edge_cut();
        int np;
        int ncol;
`ifdef TRI_SCAN_ROW_SKIP_EN
        np = 6; ncol = 3;
`else
        np = 8; ncol = 4;
`endif
        do_start(pack3(18'h3FFFF, 0, 0), '0, pack3(1, 5, 5), 4, 2);
        run_trace(12, -1, 0, -1, '0, -1);
        for (int k = 0; k < np; k++) begin
            n_checks++; if (tr_valid[k] !== 1'b1) begin n_fail++; $display("FAIL edge_cut valid k=%0d got %b expected 1", k, tr_valid[k]); end
            n_checks++; if (tr_x[k] !== XW'(k % ncol)) begin n_fail++; $display("FAIL edge_cut x k=%0d got %0d expected %0d", k, tr_x[k], k % ncol); end
            n_checks++; if (tr_y[k] !== YW'(k / ncol)) begin n_fail++; $display("FAIL edge_cut y k=%0d got %0d expected %0d", k, tr_y[k], k / ncol); end
            n_checks++; if (tr_inside[k] !== ((k % ncol) < 2)) begin n_fail++; $display("FAIL edge_cut inside k=%0d got %b expected %b", k, tr_inside[k], (k % ncol) < 2); end
            n_checks++; if (tr_last[k] !== (k == np - 1)) begin n_fail++; $display("FAIL edge_cut last k=%0d got %b expected %b", k, tr_last[k], k == np - 1); end
        end
        n_checks++; if (tr_done[np] !== 1'b1) begin n_fail++; $display("FAIL edge_cut done got %b expected 1", tr_done[np]); end
        n_checks++; if (tr_valid[np] !== 1'b0) begin n_fail++; $display("FAIL edge_cut valid after last got %b expected 0", tr_valid[np]); end
    endtask

    task automatic test_backpressure();
        int n_acc;
        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(16, 1, 3, -1, '0, -1);
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (tr_valid[k] !== 1'b1) begin n_fail++; $display("FAIL stall valid k=%0d got %b expected 1", k, tr_valid[k]); end
            n_checks++; if (tr_x[k] !== XW'(1)) begin n_fail++; $display("FAIL stall x k=%0d got %0d expected 1", k, tr_x[k]); end
            n_checks++; if (tr_y[k] !== YW'(0)) begin n_fail++; $display("FAIL stall y k=%0d got %0d expected 0", k, tr_y[k]); end
            n_checks++; if (tr_inside[k] !== 1'b1) begin n_fail++; $display("FAIL stall inside k=%0d got %b expected 1", k, tr_inside[k]); end
        end
        n_acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (tr_acc[k]) begin
                n_checks++; if (tr_x[k] !== XW'(n_acc % 4)) begin n_fail++; $display("FAIL stall accepted x #%0d got %0d expected %0d", n_acc, tr_x[k], n_acc % 4); end
                n_checks++; if (tr_y[k] !== YW'(n_acc / 4)) begin n_fail++; $display("FAIL stall accepted y #%0d got %0d expected %0d", n_acc, tr_y[k], n_acc / 4); end
                n_acc++;
            end
        end
        n_checks++; if (n_acc != 8) begin n_fail++; $display("FAIL stall pixel count got %0d expected 8", n_acc); end
        n_checks++; if (tr_done[11] !== 1'b1) begin n_fail++; $display("FAIL stall done got %b expected 1", tr_done[11]); end
    endtask

    task automatic test_wrap();
        do_start(pack3(1, 0, 0), '0, pack3(18'h1FFFF, 5, 5), 2, 1);
        run_trace(5, -1, 0, -1, '0, -1);
        n_checks++; if (tr_inside[0] !== 1'b1) begin n_fail++; $display("FAIL wrap inside(0,0) got %b expected 1", tr_inside[0]); end
        n_checks++; if (tr_x[1] !== XW'(1)) begin n_fail++; $display("FAIL wrap x got %0d expected 1", tr_x[1]); end
        n_checks++; if (tr_inside[1] !== 1'b0) begin n_fail++; $display("FAIL wrap inside(1,0) got %b expected 0", tr_inside[1]); end
        n_checks++; if (tr_last[1] !== 1'b1) begin n_fail++; $display("FAIL wrap last got %b expected 1", tr_last[1]); end
        n_checks++; if (tr_done[2] !== 1'b1) begin n_fail++; $display("FAIL wrap done got %b expected 1", tr_done[2]); end
    endtask

    task automatic test_control();
        // Start pulse with a different c mid-scan must not disturb the running scan.
        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(12, -1, 0, 3, pack3(18'h3FFFF, 18'h3FFFF, 18'h3FFFF), -1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (tr_inside[k] !== 1'b1) begin n_fail++; $display("FAIL ctrl inside k=%0d got %b expected 1", k, tr_inside[k]); end
            n_checks++; if (tr_x[k] !== XW'(k % 4)) begin n_fail++; $display("FAIL ctrl x k=%0d got %0d expected %0d", k, tr_x[k], k % 4); end
        end
        n_checks++; if (tr_last[7] !== 1'b1) begin n_fail++; $display("FAIL ctrl last got %b expected 1", tr_last[7]); end
        n_checks++; if (tr_done[8] !== 1'b1) begin n_fail++; $display("FAIL ctrl done got %b expected 1", tr_done[8]); end
        n_checks++; if (tr_busy[9] !== 1'b0) begin n_fail++; $display("FAIL ctrl busy got %b expected 0", tr_busy[9]); end

        do_start('0, '0, pack3(5, 5, 5), 0, 2);
        run_trace(3, -1, 0, -1, '0, -1);
        n_checks++; if (tr_done[0] !== 1'b1) begin n_fail++; $display("FAIL zero_box done got %b expected 1", tr_done[0]); end
        n_checks++; if (tr_valid[0] !== 1'b0) begin n_fail++; $display("FAIL zero_box valid got %b expected 0", tr_valid[0]); end
        n_checks++; if (tr_busy[1] !== 1'b0) begin n_fail++; $display("FAIL zero_box busy got %b expected 0", tr_busy[1]); end
        n_checks++; if (tr_valid[1] !== 1'b0) begin n_fail++; $display("FAIL zero_box late valid got %b expected 0", tr_valid[1]); end
    endtask

    task automatic test_back_to_back();
        // Second start at the earliest legal cycle, with c changed to an outside value.
        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(20, -1, 0, 9, pack3(18'h3FFFF, 18'h3FFFF, 18'h3FFFF), -1);
        n_checks++; if (tr_busy[9] !== 1'b0) begin n_fail++; $display("FAIL b2b idle gap busy got %b expected 0", tr_busy[9]); end
        for (int k = 10; k < 18; k++) begin
            n_checks++; if (tr_valid[k] !== 1'b1) begin n_fail++; $display("FAIL b2b valid k=%0d got %b expected 1", k, tr_valid[k]); end
            n_checks++; if (tr_x[k] !== XW'((k - 10) % 4)) begin n_fail++; $display("FAIL b2b x k=%0d got %0d expected %0d", k, tr_x[k], (k - 10) % 4); end
            n_checks++; if (tr_y[k] !== YW'((k - 10) / 4)) begin n_fail++; $display("FAIL b2b y k=%0d got %0d expected %0d", k, tr_y[k], (k - 10) / 4); end
            n_checks++; if (tr_inside[k] !== 1'b0) begin n_fail++; $display("FAIL b2b inside k=%0d got %b expected 0", k, tr_inside[k]); end
        end
        n_checks++; if (tr_last[17] !== 1'b1) begin n_fail++; $display("FAIL b2b last got %b expected 1", tr_last[17]); end
        n_checks++; if (tr_done[18] !== 1'b1) begin n_fail++; $display("FAIL b2b done got %b expected 1", tr_done[18]); end
    endtask

    task automatic test_reset_mid();
        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(5, -1, 0, -1, '0, 2);
        n_checks++; if (tr_x[2] !== XW'(2)) begin n_fail++; $display("FAIL rst_mid pre x got %0d expected 2", tr_x[2]); end
        n_checks++; if (tr_busy[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b expected 0", tr_busy[3]); end
        n_checks++; if (tr_valid[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid got %b expected 0", tr_valid[3]); end
        n_checks++; if (tr_x[3] !== '0) begin n_fail++; $display("FAIL rst_mid x got %0d expected 0", tr_x[3]); end
        n_checks++; if (tr_y[3] !== '0) begin n_fail++; $display("FAIL rst_mid y got %0d expected 0", tr_y[3]); end
        n_checks++; if (tr_done[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid done got %b expected 0", tr_done[3]); end
        n_checks++; if (tr_last[3] !== 1'b0) begin n_fail++; $display("FAIL rst_mid last got %b expected 0", tr_last[3]); end

        do_start('0, '0, pack3(5, 5, 5), 4, 2);
        run_trace(10, -1, 0, -1, '0, -1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (tr_valid[k] !== 1'b1) begin n_fail++; $display("FAIL rst_mid rescan valid k=%0d got %b expected 1", k, tr_valid[k]); end
            n_checks++; if (tr_x[k] !== XW'(k % 4)) begin n_fail++; $display("FAIL rst_mid rescan x k=%0d got %0d expected %0d", k, tr_x[k], k % 4); end
            n_checks++; if (tr_y[k] !== YW'(k / 4)) begin n_fail++; $display("FAIL rst_mid rescan y k=%0d got %0d expected %0d", k, tr_y[k], k / 4); end
        end
        n_checks++; if (tr_done[8] !== 1'b1) begin n_fail++; $display("FAIL rst_mid rescan done got %b expected 1", tr_done[8]); end
    endtask

    initial begin
        test_reset();
        test_full_box();
        test_edge_cut();
        test_backpressure();
        test_wrap();
        test_control();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_scan.md
# tri_scan

Parametrised triangle scan engine; next generation of the single-pixel edge-function tile. Holds EDGES incremental edge functions and walks a WIDTH×HEIGHT bounding box on its own in raster order. Emits one pixel per accepted handshake, each with coordinates and an inside flag. Sits between triangle setup, which supplies a/b/c and box size, and the pixel/shading stage.

## Interface
- `W`, 18: edge-function width, two's complement.
- `EDGES`, 3: number of edge functions.
- `XW`, 10: x coordinate / box width field.
- `YW`, 10: y coordinate / box height field.

- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `a` in W*EDGES: per-edge x increment; edge k at bits [W*k+W-1:W*k].
- `b` in W*EDGES: per-edge y increment, same packing.
- `c` in W*EDGES: per-edge value at pixel (0,0), same packing.
- `width` in XW: columns in box.
- `height` in YW: rows in box.
- `start` in 1: request a scan; accepted only when busy=0.
- `busy` out 1: scan in progress.
- `out_valid` out 1: pixel presented.
- `out_ready` in 1: consumer accepts pixel.
- `out_x` out XW: pixel column.
- `out_y` out YW: pixel row.
- `out_inside` out 1: all EDGES values have a clear sign bit (>= 0). Gated by out_valid.
- `out_last` out 1: final pixel of the scan.
- `done` out 1: one-cycle pulse after the scan ends.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Latch a, b, width, height.
  - Load e <= c and row register er <= c.
  - x=0, y=0.
  - Go to RUN, or to DONE if width==0 or height==0 (no pixels emitted).
- RUN: out_valid=1. The pixel (x, y, inside(e)) is held until out_valid&&out_ready ("accept"). On accept:
  - If x < width-1 and not row-skip: x++, e <= e + a per edge.
  - Otherwise, if y < height-1: y++, x=0, er <= er + b, e <= er + b.
  - Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic: each edge is an independent W-bit add that wraps modulo 2^W. No saturation. Inside test uses bit W-1 of each edge only.
- Register budget: 2*EDGES*W for e/er, plus EDGES*W each for latched a and b.
- busy=1 in RUN and DONE. start while busy is ignored; no effect on the current scan.
- a/b/c/width/height changes after start do not affect the running scan.
- reset at any time:
  - Return to IDLE.
  - busy, out_valid, out_last, done, out_x, out_y, e, er all 0 on the following cycle.
  - A pending pixel is dropped.
- Reset values: busy=0, out_valid=0, out_x=0, out_y=0, out_inside=0, out_last=0, done=0.

## Timing
- start sampled at cycle T (IDLE) -> out_valid=1 with pixel (0,0) at T+1.
- Full-throughput rate: one pixel per cycle with out_ready held high; row change costs no bubble.
- Outputs are stable while out_valid&&!out_ready. out_valid never drops without an accept, except on reset.
- out_last is high together with out_valid on the final pixel only.
- Last accept at cycle T -> out_valid=0 and done=1 at T+1 -> IDLE and busy=0 at T+2. The earliest new start is sampled at T+2.
- Zero-size box: start at T -> done=1 at T+1, with no out_valid.

## Configuration
- `TRI_SCAN_ROW_SKIP_EN`: defined -> row early-exit.
  - A per-row flag seen_in is set when an inside pixel is accepted, and cleared on row advance.
  - Accepting an outside pixel with seen_in=1 ends the row immediately. The remaining columns are not emitted, because a convex triangle cannot re-enter the row.
  - If that happens on the last row, the pixel carries out_last=1.
- Undefined: every pixel of the box is emitted, and seen_in logic is absent.

## Test plan
- Full box: EDGES=3, a=b=0, every c=5, width=4, height=2, out_ready=1. Required: 8 pixels at T+1..T+8 in order (0,0)…(3,0),(0,1)…(3,1), all inside=1. out_last only on (3,1); done at T+9; busy=0 at T+10.
- Edge cut: edge0 a=-1, b=0, c=1; others a=b=0, c=5; width=4, height=2.
  - Without macro: 8 pixels, inside 1,1,0,0 per row.
  - With macro: 3 pixels per row (x=0..2), inside 1,1,0. out_last on (2,1).
- Backpressure: full-box config with out_ready low for 3 cycles at pixel (1,0). Required: out_x=1, out_y=0, out_inside unchanged over those cycles; no pixel lost or duplicated; total 8.
- Wrap: edge0 c=0x1FFFF, a=1; others a=b=0, c=5; width=2, height=1. Required: (0,0) inside=1, (1,0) inside=0, because e0 wraps to 0x20000.
- Control: start pulsed mid-scan -> ignored, scan completes normally. width=0 -> done at T+1 with no out_valid.
- Reset: reset asserted mid-scan -> next cycle busy=0, out_valid=0, out_x=0, out_y=0. A following start scans from (0,0).
